flopr_pipe_param: RTL and testbench
===================================

// Module: flopr_pipe_param
// PURPOSE
//   Parametrised multi-stage register pipeline with per-stage valid tracking, stall (enable) and flush.
//   Generalises the single resettable flop to DEPTH stages of WIDTH bits.
//   Used between datapath stages of the lab CPU where a value must be delayed, held on a stall
//   and squashed on a branch/exception flush.
// PARAMETERS
//   WIDTH      32   data width of every stage, >= 1
//   DEPTH      3    number of register stages (latency), >= 1; DEPTH = 0 is illegal (elaboration error)
//   RESET_VAL  0    value loaded into every data stage on rst or flush, WIDTH bits
// PORTS
//   clk          in   1                    rising-edge clock
//   rst          in   1                    synchronous reset, active-high
//   en           in   1                    1 = advance pipeline, 0 = stall (hold all stages)
//   flush        in   1                    synchronous squash of all stages
//   in_valid     in   1                    d_in carries a valid item this cycle
//   d_in         in   WIDTH                data into stage 0
//   out_valid    out  1                    valid bit of last stage (stage DEPTH-1)
//   d_out        out  WIDTH                data of last stage
//   stage_valid  out  DEPTH                valid bit of each stage, bit i = stage i (for hazard logic)
//   count        out  $clog2(DEPTH+1)      number of valid stages, 0..DEPTH
// BEHAVIOUR
//   - All state updates on posedge clk only; outputs are direct register outputs, no comb path from inputs.
//   - Priority per edge: rst > flush > en > hold.
//   - rst=1: every data stage = RESET_VAL, every valid = 0, count = 0; in_valid/d_in/en/flush ignored.
//   - flush=1 (rst=0): same clearing as reset regardless of en; the item presented that cycle is dropped.
//   - en=1 (rst=0, flush=0): stage0 <= {in_valid, d_in}; stage i <= stage i-1 for i = 1..DEPTH-1;
//     the last stage's old contents leave the pipeline (no backpressure, no drop detection).
//   - en=0 (rst=0, flush=0): every stage, valid and count hold; d_in/in_valid ignored.
//   - Latency: an item accepted at edge N with en high on all following edges appears on
//     d_out/out_valid after edge N+DEPTH-1, i.e. DEPTH edges including the capture edge.
//     Stalled cycles add 1:1 to latency.
//   - Invalid items (in_valid=0) still shift data in (data is don't-care when valid=0; the bench
//     checks only valid items).
//   - count is registered, updated in the same edge as the valid bits:
//     count_next = count + in_valid - out_valid when en=1; 0 on rst/flush; hold when en=0.
//     Never exceeds DEPTH, never underflows.
//   - count == popcount(stage_valid) at all times (assertion).
//   - DEPTH=1: single flop with valid; d_out follows d_in one edge later when en=1.
//   - Reset or flush mid-stream: all in-flight items lost; first valid output after release appears
//     exactly DEPTH enabled edges after the next accepted item.
// TESTING
//   1. WIDTH=32, DEPTH=3: rst 2 cycles -> d_out=0, out_valid=0, count=0, stage_valid=3'b000.
//   2. en=1, in_valid=1, d_in=400,401,402,403 on consecutive edges -> d_out 400 after 3rd edge,
//      then 401,402,403; count 1,2,3,3.
//   3. Pipeline full (400,401,402), en=0 for 4 cycles with d_in=999 -> d_out stays 400,
//      count stays 3; release en -> 401,402 follow, 999 never appears.
//   4. Full pipeline, flush=1 with en=1, in_valid=1, d_in=7 -> next edge stage_valid=000, count=0,
//      d_out=RESET_VAL; 7 never appears.
//   5. rst=1 and flush=1 asserted mid-stream with en=0 -> cleared identically to test 4;
//      RESET_VAL=32'hDEAD_BEEF shows on d_out.
//   6. Alternating in_valid 1,0,1,0 (d_in 10,11,12,13), DEPTH=1 and DEPTH=4 builds ->
//      out_valid pattern delayed by DEPTH edges, valid data 10,12; count==popcount(stage_valid) every cycle.

Source files
------------

// File: rtl/flopr_pipe_param.sv
// DEPTH-stage register pipeline of WIDTH bits with a valid bit per stage, stall (en),
// flush, and a registered count of valid stages.
module flopr_pipe_param #(
  parameter int                WIDTH     = 32,
  parameter int                DEPTH     = 3,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             d_in,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             d_out,
  output logic [DEPTH-1:0]             stage_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("flopr_pipe_param: DEPTH must be at least 1");
    end
  endgenerate

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CW-1:0]    count_q, count_d;

  // Priority below reset: flush > en > hold. Reset itself is applied in the flop block.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = RESET_VAL;
      end
      valid_d = '0;
      count_d = '0;
    end else if (en) begin
      data_d[0]  = d_in;
      valid_d[0] = in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      // Modular CW-bit arithmetic: the transient count+1 may wrap, the final result cannot.
      count_d = count_q + CW'(in_valid) - CW'(valid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
      valid_q <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign out_valid   = valid_q[DEPTH-1];
  assign d_out       = data_q[DEPTH-1];
  assign stage_valid = valid_q;
  assign count       = count_q;

  a_count_matches_valids : assert property (@(posedge clk) count_q == CW'($countones(valid_q)));

endmodule

// File: tb/tb_flopr_pipe_param.sv
// Bench for flopr_pipe_param: four builds (DEPTH 3/3/1/4) share one stimulus stream and are
// checked against a history-log model, a directed vector table and hand sequences.
module tb_flopr_pipe_param;

  logic        clk = 1'b0;
  logic        rst, en, flush, in_valid;
  logic [31:0] d_in;

  logic        ov3, ov3b, ov1, ov4;
  logic [31:0] do3, do3b, do1, do4;
  logic [2:0]  sv3, sv3b;
  logic [0:0]  sv1;
  logic [3:0]  sv4;
  logic [1:0]  c3, c3b;
  logic [0:0]  c1;
  logic [2:0]  c4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flopr_pipe_param #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'h0)) u3 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .d_in(d_in),
    .out_valid(ov3), .d_out(do3), .stage_valid(sv3), .count(c3));
  flopr_pipe_param #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'hDEAD_BEEF)) u3b (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .d_in(d_in),
    .out_valid(ov3b), .d_out(do3b), .stage_valid(sv3b), .count(c3b));
  flopr_pipe_param #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'h0)) u1 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .d_in(d_in),
    .out_valid(ov1), .d_out(do1), .stage_valid(sv1), .count(c1));
  flopr_pipe_param #(.WIDTH(32), .DEPTH(4), .RESET_VAL(32'h0)) u4 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .d_in(d_in),
    .out_valid(ov4), .d_out(do4), .stage_valid(sv4), .count(c4));

  // Reference model: log of every item accepted on an enabled edge since the last clear.
  // A DEPTH-d pipeline exposes the d newest entries; its output is the entry d edges back.
  typedef struct {
    logic        v;
    logic [31:0] d;
  } ent_t;
  ent_t hist[$];

  typedef struct {
    logic        r, e, f, iv;
    logic [31:0] d;
    logic        ov;
    logic [31:0] dout;
    int          cnt;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", what, act, exp);
    end
  endtask

  task automatic check_one(input string nm, input int dep, input logic [31:0] rv,
                           input logic ov, input logic [31:0] dout,
                           input logic [3:0] sv, input int cnt);
    int          n;
    int          ecnt;
    logic [3:0]  esv;
    logic        eov;
    n    = hist.size();
    ecnt = 0;
    esv  = '0;
    for (int i = 0; i < dep; i++) begin
      if (n > i && hist[n-1-i].v) begin
        esv[i] = 1'b1;
        ecnt++;
      end
    end
    eov = (n >= dep) ? hist[n-dep].v : 1'b0;
    chk({nm, " out_valid"}, 32'(ov), 32'(eov));
    chk({nm, " stage_valid"}, 32'(sv), 32'(esv));
    chk({nm, " count"}, cnt, ecnt);
    chk({nm, " count_vs_popcount"}, cnt, $countones(sv));
    if (n < dep) chk({nm, " d_out_reset"}, dout, rv);
    else if (eov) chk({nm, " d_out"}, dout, hist[n-dep].d);
  endtask

  task automatic check_model();
    check_one("d3", 3, 32'h0, ov3, do3, {1'b0, sv3}, int'(c3));
    check_one("d3b", 3, 32'hDEAD_BEEF, ov3b, do3b, {1'b0, sv3b}, int'(c3b));
    check_one("d1", 1, 32'h0, ov1, do1, {3'b000, sv1}, int'(c1));
    check_one("d4", 4, 32'h0, ov4, do4, sv4, int'(c4));
  endtask

  task automatic step(input logic r, input logic e, input logic f, input logic iv,
                      input logic [31:0] d);
    ent_t x;
    rst = r; en = e; flush = f; in_valid = iv; d_in = d;
    @(posedge clk);
    if (r || f) hist.delete();
    else if (e) begin
      x.v = iv;
      x.d = d;
      hist.push_back(x);
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic add(input logic r, input logic e, input logic f, input logic iv,
                     input logic [31:0] d, input logic ov, input logic [31:0] dout, input int cnt);
    vec_t v;
    v.r = r; v.e = e; v.f = f; v.iv = iv; v.d = d; v.ov = ov; v.dout = dout; v.cnt = cnt;
    vq.push_back(v);
  endtask

  initial begin
    logic [7:0] p1, p4;
    rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; d_in = '0;

    // rst, fill, stall with 999, release, flush dropping 7, refill, rst+flush while stalled
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'd0,   1'b0, 32'd0,   0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 32'd0,   1'b0, 32'd0,   0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 32'd400, 1'b0, 32'd0,   1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 32'd401, 1'b0, 32'd0,   2);
    add(1'b0, 1'b1, 1'b0, 1'b1, 32'd402, 1'b1, 32'd400, 3);
    for (int k = 0; k < 4; k++) add(1'b0, 1'b0, 1'b0, 1'b1, 32'd999, 1'b1, 32'd400, 3);
    add(1'b0, 1'b1, 1'b0, 1'b1, 32'd403, 1'b1, 32'd401, 3);
    add(1'b0, 1'b1, 1'b0, 1'b1, 32'd404, 1'b1, 32'd402, 3);
    add(1'b0, 1'b1, 1'b0, 1'b1, 32'd405, 1'b1, 32'd403, 3);
    add(1'b0, 1'b1, 1'b1, 1'b1, 32'd7,   1'b0, 32'd0,   0);
    for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 32'd20,  1'b0, 32'd0,   1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 32'd21,  1'b0, 32'd0,   2);
    add(1'b0, 1'b1, 1'b0, 1'b1, 32'd22,  1'b1, 32'd20,  3);
    add(1'b1, 1'b0, 1'b1, 1'b1, 32'd9,   1'b0, 32'd0,   0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 32'd30,  1'b0, 32'd0,   1);

    @(negedge clk);
    for (int k = 0; k < vq.size(); k++) begin
      step(vq[k].r, vq[k].e, vq[k].f, vq[k].iv, vq[k].d);
      chk($sformatf("vec%0d out_valid", k), 32'(ov3), 32'(vq[k].ov));
      chk($sformatf("vec%0d d_out", k), do3, vq[k].dout);
      chk($sformatf("vec%0d count", k), int'(c3), vq[k].cnt);
      if (vq[k].r) begin
        chk($sformatf("vec%0d reset_val_d_out", k), do3b, 32'hDEAD_BEEF);
        chk($sformatf("vec%0d reset_stage_valid", k), 32'(sv3b), 32'd0);
      end
    end

    // Alternating valids 10,11,12,13 through DEPTH=1 and DEPTH=4
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    p1 = 8'b0000_0101;
    p4 = 8'b0010_1000;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b0, (k < 4) ? ~k[0] : 1'b0, (k < 4) ? 32'(10 + k) : 32'd0);
      chk($sformatf("alt%0d d1 out_valid", k), 32'(ov1), 32'(p1[k]));
      chk($sformatf("alt%0d d4 out_valid", k), 32'(ov4), 32'(p4[k]));
      if (p1[k]) chk($sformatf("alt%0d d1 d_out", k), do1, 32'(10 + k));
      if (p4[k]) chk($sformatf("alt%0d d4 d_out", k), do4, 32'(10 + k - 3));
    end

    // Random traffic with occasional reset/flush and frequent stalls
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
           1'($urandom_range(0, 1)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
